// File: rtl/i2c_pkg.sv
// Shared I2C definitions: field widths, FSM state encoding and quarter-phase codes.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_DATA_W = 8;
  localparam logic [I2C_ADDR_W-1:0] DEFAULT_SLAVE_ADDR = 7'h55;

  // State codes are fixed numerically so the responder can reuse them.
  localparam int unsigned ST_W = 4;
  localparam logic [ST_W-1:0] ST_IDLE     = 4'd0;
  localparam logic [ST_W-1:0] ST_START    = 4'd1;
  localparam logic [ST_W-1:0] ST_ADDR     = 4'd2;
  localparam logic [ST_W-1:0] ST_ADDR_ACK = 4'd3;
  localparam logic [ST_W-1:0] ST_WR_DATA  = 4'd4;
  localparam logic [ST_W-1:0] ST_WR_ACK   = 4'd5;
  localparam logic [ST_W-1:0] ST_RD_DATA  = 4'd6;
  localparam logic [ST_W-1:0] ST_RD_NACK  = 4'd7;
  localparam logic [ST_W-1:0] ST_STOP     = 4'd8;

  typedef enum logic [ST_W-1:0] {
    S_IDLE     = ST_IDLE,
    S_START    = ST_START,
    S_ADDR     = ST_ADDR,
    S_ADDR_ACK = ST_ADDR_ACK,
    S_WR_DATA  = ST_WR_DATA,
    S_WR_ACK   = ST_WR_ACK,
    S_RD_DATA  = ST_RD_DATA,
    S_RD_NACK  = ST_RD_NACK,
    S_STOP     = ST_STOP
  } state_e;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  function automatic logic [I2C_DATA_W-1:0] addr_byte(input logic [I2C_ADDR_W-1:0] a,
                                                      input logic rw);
    return {a, rw};
  endfunction

endpackage

// File: rtl/i2c_clk_gen.sv
// Quarter-period tick generator: one tick every CLK_DIV cycles plus a 2-bit phase index.
module i2c_clk_gen
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  output logic       tick_c_o,
  output logic [1:0] phase_o
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [1:0]       phase_q;

  // Tick marks the last cycle of the current quarter phase.
  assign tick_c_o = en_i && (div_q == DIV_MAX);
  assign phase_o  = phase_q;

  always_ff @(posedge clk) begin
    if (reset || !en_i) begin
      div_q   <= '0;
      phase_q <= Q0;
    end else if (tick_c_o) begin
      div_q   <= '0;
      phase_q <= phase_q + 2'd1;
    end else begin
      div_q   <= div_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C initiator: START, address+RW, ACK, one data byte, ACK/NACK, STOP.
module i2c_master
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [I2C_ADDR_W-1:0] addr,
  input  logic                  rw,
  input  logic [I2C_DATA_W-1:0] wdata,
  output logic [I2C_DATA_W-1:0] rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  ack_err,
  inout  wire                   sda,
  output logic                  scl
);

  state_e                state_q;
  logic                  scl_q;
  logic                  sda_oe_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  ack_err_q;
  logic                  nack_q;
  logic [I2C_DATA_W-1:0] rdata_q;
  logic [I2C_DATA_W-1:0] tx_q;
  logic [I2C_DATA_W-1:0] rx_q;
  logic [I2C_DATA_W-1:0] wdata_q;
  logic                  rw_q;
  logic [2:0]            bit_cnt_q;

  logic                  tick;
  logic [1:0]            phase;
  logic                  sda_in;

  i2c_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk      (clk),
    .reset    (reset),
    .en_i     (state_q != S_IDLE),
    .tick_c_o (tick),
    .phase_o  (phase)
  );

  // Open-drain: only ever pull low or release.
  assign sda     = sda_oe_q ? 1'b0 : 1'bz;
  assign sda_in  = sda;
  assign scl     = scl_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign rdata   = rdata_q;

  // On each tick the current quarter ends; the case arm sets up the next quarter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      scl_q     <= 1'b1;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      nack_q    <= 1'b0;
      rdata_q   <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      wdata_q   <= '0;
      rw_q      <= 1'b0;
      bit_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          busy_q   <= 1'b0;
          scl_q    <= 1'b1;
          sda_oe_q <= 1'b0;
          if (start && !busy_q) begin
            state_q   <= S_START;
            busy_q    <= 1'b1;
            tx_q      <= addr_byte(addr, rw);
            rw_q      <= rw;
            wdata_q   <= wdata;
            ack_err_q <= 1'b0;
            nack_q    <= 1'b0;
            bit_cnt_q <= '0;
          end
        end
        default: begin
          if (tick) begin
            case (phase)
              Q0: scl_q <= 1'b1;
              Q1: begin
                case (state_q)
                  S_START:               sda_oe_q <= 1'b1;
                  S_STOP:                sda_oe_q <= 1'b0;
                  S_ADDR_ACK, S_WR_ACK:  if (sda_in) nack_q <= 1'b1;
                  S_RD_DATA:             rx_q <= {rx_q[6:0], sda_in};
                  default: ;
                endcase
              end
              Q2: begin
                if (state_q != S_START && state_q != S_STOP) scl_q <= 1'b0;
              end
              default: begin
                scl_q <= 1'b0;
                case (state_q)
                  S_START: begin
                    state_q   <= S_ADDR;
                    sda_oe_q  <= ~tx_q[7];
                    bit_cnt_q <= '0;
                  end
                  S_ADDR, S_WR_DATA: begin
                    if (bit_cnt_q == 3'd7) begin
                      state_q  <= (state_q == S_ADDR) ? S_ADDR_ACK : S_WR_ACK;
                      sda_oe_q <= 1'b0;
                    end else begin
                      bit_cnt_q <= bit_cnt_q + 3'd1;
                      tx_q      <= {tx_q[6:0], 1'b0};
                      sda_oe_q  <= ~tx_q[6];
                    end
                  end
                  S_ADDR_ACK: begin
                    bit_cnt_q <= '0;
                    if (nack_q) begin
                      state_q  <= S_STOP;
                      sda_oe_q <= 1'b1;
                    end else if (rw_q) begin
                      state_q  <= S_RD_DATA;
                      sda_oe_q <= 1'b0;
                    end else begin
                      state_q  <= S_WR_DATA;
                      tx_q     <= wdata_q;
                      sda_oe_q <= ~wdata_q[7];
                    end
                  end
                  S_RD_DATA: begin
                    if (bit_cnt_q == 3'd7) begin
                      state_q  <= S_RD_NACK;
                      rdata_q  <= rx_q;
                      sda_oe_q <= 1'b0;
                    end else begin
                      bit_cnt_q <= bit_cnt_q + 3'd1;
                    end
                  end
                  S_WR_ACK, S_RD_NACK: begin
                    state_q  <= S_STOP;
                    sda_oe_q <= 1'b1;
                  end
                  S_STOP: begin
                    state_q   <= S_IDLE;
                    scl_q     <= 1'b1;
                    sda_oe_q  <= 1'b0;
                    done_q    <= 1'b1;
                    ack_err_q <= nack_q;
                  end
                  default: state_q <= S_IDLE;
                endcase
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule
